// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the cache-line memory port arbiter.
// Line offset bits are dropped so the memory engine only ever sees line-aligned addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int LINEBITS    = 512;
    localparam int LINEOFFBITS = 6;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Client and memory-engine signal bundle for mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the clients and engine together.
interface mem_bus_arbiter_if #(
    parameter int NREQ     = 2,
    parameter int ADDRBITS = 64,
    parameter int LINEBITS = 512
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]          req_cyc;
    logic [NREQ-1:0]          req_we;
    logic [NREQ*ADDRBITS-1:0] req_addr;
    logic [NREQ*LINEBITS-1:0] req_wdata;
    logic [NREQ-1:0]          resp_cyc;
    logic [LINEBITS-1:0]      resp_rdata;
    logic                     mem_reqcyc;
    logic                     mem_we;
    logic [ADDRBITS-1:0]      mem_addr;
    logic [LINEBITS-1:0]      mem_wdata;
    logic                     mem_respcyc;
    logic [LINEBITS-1:0]      mem_rdata;
    logic [IDXW-1:0]          grant_idx;

    modport slave (
        input  req_cyc, req_we, req_addr, req_wdata, mem_respcyc, mem_rdata,
        output resp_cyc, resp_rdata, mem_reqcyc, mem_we, mem_addr, mem_wdata, grant_idx
    );

    modport master (
        output req_cyc, req_we, req_addr, req_wdata, mem_respcyc, mem_rdata,
        input  resp_cyc, resp_rdata, mem_reqcyc, mem_we, mem_addr, mem_wdata, grant_idx
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-wide memory engine between NREQ cache clients.
// One line transaction in flight at a time; request fields are latched at grant.
//
// state | meaning
// IDLE  | no transaction; pick next client from rr_ptr when any req_cyc is high
// ISSUE | mem_reqcyc held with latched addr/we/wdata until mem_respcyc
// RESP  | one-cycle resp_cyc pulse to grantee; no re-grant this cycle
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDRBITS = 64,
    parameter int LINEBITS = mem_arb_pkg::LINEBITS
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t          state_q, state_nxt;
    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_nxt;
    logic [IDXW-1:0]     grant_q, grant_nxt;
    logic [NREQ-1:0]     resp_cyc_q, resp_cyc_nxt;
    logic [LINEBITS-1:0] resp_rdata_q, resp_rdata_nxt;
    logic                mem_reqcyc_q, mem_reqcyc_nxt;
    logic                mem_we_q, mem_we_nxt;
    logic [ADDRBITS-1:0] mem_addr_q, mem_addr_nxt;
    logic [LINEBITS-1:0] mem_wdata_q, mem_wdata_nxt;

    logic [IDXW-1:0]     pick_idx;
    logic                pick_valid;
    logic [ADDRBITS-1:0] sel_addr;

    rr_pick #(.N(NREQ), .PW(IDXW)) u_rr_pick (
        .req   (bus.req_cyc),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_nxt      = state_q;
        rr_ptr_nxt     = rr_ptr_q;
        grant_nxt      = grant_q;
        resp_cyc_nxt   = '0;
        resp_rdata_nxt = resp_rdata_q;
        mem_reqcyc_nxt = mem_reqcyc_q;
        mem_we_nxt     = mem_we_q;
        mem_addr_nxt   = mem_addr_q;
        mem_wdata_nxt  = mem_wdata_q;
        sel_addr       = bus.req_addr[int'(pick_idx)*ADDRBITS +: ADDRBITS];

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt      = pick_idx;
                    rr_ptr_nxt     = (pick_idx == IDXW'(NREQ-1)) ? '0 : pick_idx + IDXW'(1);
                    mem_addr_nxt   = {sel_addr[ADDRBITS-1:LINEOFFBITS], LINEOFFBITS'(0)};
                    mem_we_nxt     = bus.req_we[pick_idx];
                    mem_wdata_nxt  = bus.req_wdata[int'(pick_idx)*LINEBITS +: LINEBITS];
                    mem_reqcyc_nxt = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                // Completion is taken even if the client dropped its request mid-flight.
                if (bus.mem_respcyc) begin
                    mem_reqcyc_nxt = 1'b0;
                    resp_rdata_nxt = mem_we_q ? '0 : bus.mem_rdata;
                    resp_cyc_nxt   = NREQ'(1) << grant_q;
                    state_nxt      = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            resp_cyc_q   <= '0;
            resp_rdata_q <= '0;
            mem_reqcyc_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_nxt;
            rr_ptr_q     <= rr_ptr_nxt;
            grant_q      <= grant_nxt;
            resp_cyc_q   <= resp_cyc_nxt;
            resp_rdata_q <= resp_rdata_nxt;
            mem_reqcyc_q <= mem_reqcyc_nxt;
            mem_we_q     <= mem_we_nxt;
            mem_addr_q   <= mem_addr_nxt;
            mem_wdata_q  <= mem_wdata_nxt;
        end
    end

    assign bus.resp_cyc   = resp_cyc_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_reqcyc = mem_reqcyc_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.grant_idx  = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 2-client instance for the protocol cases
// and a 3-client instance for round-robin ordering under continuous load.
module tb_mem_bus_arbiter;

    localparam int AB = 64;
    localparam int LB = 512;

    logic clk;
    logic reset;

    int vec_cnt;
    int miscompare_cnt;

    mem_bus_arbiter_if #(.NREQ(2), .ADDRBITS(AB), .LINEBITS(LB)) bus2 ();
    mem_bus_arbiter_if #(.NREQ(3), .ADDRBITS(AB), .LINEBITS(LB)) bus3 ();

    mem_bus_arbiter #(.NREQ(2), .ADDRBITS(AB), .LINEBITS(LB)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mem_bus_arbiter #(.NREQ(3), .ADDRBITS(AB), .LINEBITS(LB)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_reqcyc2(input string tag);
        for (int i = 0; i < 20 && !bus2.mem_reqcyc; i++) tick();
        chk(tag, LB'(bus2.mem_reqcyc), LB'(1));
    endtask

    // Serve one outstanding grant on the 2-client instance.
    task automatic txn2(input string tag, input int exp_grant, input logic [LB-1:0] rdata,
                        input logic [LB-1:0] exp_rdata, input logic [1:0] drop_mask);
        wait_reqcyc2({tag, "_req"});
        chk({tag, "_grant"}, LB'(bus2.grant_idx), LB'(exp_grant));
        bus2.mem_respcyc = 1'b1;
        bus2.mem_rdata   = rdata;
        tick();
        bus2.mem_respcyc = 1'b0;
        bus2.mem_rdata   = '0;
        chk({tag, "_resp"}, LB'(bus2.resp_cyc), LB'(2'b01 << exp_grant));
        chk({tag, "_rdata"}, bus2.resp_rdata, exp_rdata);
        chk({tag, "_reqlow"}, LB'(bus2.mem_reqcyc), LB'(0));
        bus2.req_cyc = bus2.req_cyc & ~drop_mask;
        tick();
        chk({tag, "_pulse1"}, LB'(bus2.resp_cyc), LB'(0));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    logic [LB-1:0] pat_a5, pat_c3, pat_beef;

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        pat_a5   = {64{8'hA5}};
        pat_c3   = {64{8'hC3}};
        pat_beef = {16{32'hDEADBEEF}};

        reset = 1'b1;
        bus2.req_cyc = '0; bus2.req_we = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.mem_respcyc = 1'b0; bus2.mem_rdata = '0;
        bus3.req_cyc = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
        bus3.mem_respcyc = 1'b0; bus3.mem_rdata = '0;
        tick();
        tick();
        chk("rst_reqcyc", LB'(bus2.mem_reqcyc), LB'(0));
        chk("rst_resp", LB'(bus2.resp_cyc), LB'(0));
        chk("rst_addr", LB'(bus2.mem_addr), LB'(0));
        chk("rst_grant", LB'(bus2.grant_idx), LB'(0));
        reset = 1'b0;
        tick();

        // 1: single client read, one-cycle issue latency, line-aligned address
        bus2.req_addr[0 +: AB] = 64'h1000_0047;
        bus2.req_cyc = 2'b01;
        tick();
        chk("t1_lat", LB'(bus2.mem_reqcyc), LB'(1));
        chk("t1_addr", LB'(bus2.mem_addr), LB'(64'h1000_0040));
        chk("t1_we", LB'(bus2.mem_we), LB'(0));
        txn2("t1", 0, pat_a5, pat_a5, 2'b01);

        // 2: both request with rr_ptr=0, then pointer wrap on the third round
        pulse_reset();
        bus2.req_addr[64 +: AB] = 64'h1000_0080;
        bus2.req_cyc = 2'b11;
        txn2("t2a", 0, pat_a5, pat_a5, 2'b01);
        txn2("t2b", 1, pat_c3, pat_c3, 2'b10);
        bus2.req_cyc = 2'b11;
        txn2("t2c", 0, pat_a5, pat_a5, 2'b11);

        // 3: client 1 line write; read data from engine must not leak to the client
        bus2.req_addr[64 +: AB]  = 64'h2000_0000;
        bus2.req_wdata[LB +: LB] = pat_beef;
        bus2.req_we  = 2'b10;
        bus2.req_cyc = 2'b10;
        wait_reqcyc2("t3_req");
        chk("t3_we", LB'(bus2.mem_we), LB'(1));
        chk("t3_wdata", bus2.mem_wdata, pat_beef);
        chk("t3_addr", LB'(bus2.mem_addr), LB'(64'h2000_0000));
        txn2("t3", 1, pat_a5, '0, 2'b10);
        bus2.req_we = '0;

        // 4: client 0 drops its request during ISSUE; access still completes
        bus2.req_addr[0 +: AB] = 64'h3000_0100;
        bus2.req_cyc = 2'b01;
        wait_reqcyc2("t4_req");
        bus2.req_cyc = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold", LB'(bus2.mem_reqcyc), LB'(1));
            chk("t4_addr_stable", LB'(bus2.mem_addr), LB'(64'h3000_0100));
        end
        txn2("t4", 0, pat_c3, pat_c3, 2'b00);

        // 6a: spurious engine completion while idle
        bus2.mem_respcyc = 1'b1;
        tick();
        bus2.mem_respcyc = 1'b0;
        chk("t6_spur_resp", LB'(bus2.resp_cyc), LB'(0));
        chk("t6_spur_req", LB'(bus2.mem_reqcyc), LB'(0));
        bus2.req_cyc = 2'b10;
        tick();
        chk("t6_after_lat", LB'(bus2.mem_reqcyc), LB'(1));
        txn2("t6a", 1, pat_c3, pat_c3, 2'b10);

        // 5: asynchronous reset while in ISSUE with rr_ptr advanced past client 0
        bus2.req_cyc = 2'b01;
        tick();
        chk("t5_issue", LB'(bus2.mem_reqcyc), LB'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_req", LB'(bus2.mem_reqcyc), LB'(0));
        chk("t5_async_resp", LB'(bus2.resp_cyc), LB'(0));
        chk("t5_async_addr", LB'(bus2.mem_addr), LB'(0));
        bus2.req_cyc = 2'b00;
        #2;
        reset = 1'b0;
        tick();
        bus2.req_cyc = 2'b11;
        txn2("t5_after", 0, pat_a5, pat_a5, 2'b11);

        // 6b: continuous load on three clients
        bus3.req_cyc = 3'b111;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 20 && !bus3.mem_reqcyc; i++) tick();
            chk("rr3_req", LB'(bus3.mem_reqcyc), LB'(1));
            chk("rr3_grant", LB'(bus3.grant_idx), LB'(t % 3));
            bus3.mem_respcyc = 1'b1;
            bus3.mem_rdata   = LB'(t + 16);
            tick();
            bus3.mem_respcyc = 1'b0;
            chk("rr3_resp", LB'(bus3.resp_cyc), LB'(3'b001 << (t % 3)));
            chk("rr3_rdata", bus3.resp_rdata, LB'(t + 16));
        end
        bus3.req_cyc = 3'b000;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
